cnn_conv_array: RTL and testbench
=================================

# cnn_conv_array

Parametrised, fully pipelined convolution array: each beat takes one window of `WINDOW_SIZE` signed samples and produces `NUM_FILTERS` requantised outputs, all aligned in a single output beat. It adds double-buffered weight/bias storage, bias add, round/shift/saturate requantisation, optional ReLU, `last` passthrough and valid/ready backpressure. It sits between the window generator and the pooling/writeback stage.

## Interface
- `DATA_W`, 8: signed sample and output width
- `WEIGHT_W`, 8: signed weight width
- `ACC_W`, 24: signed accumulator and bias width
- `WINDOW_SIZE`, 9: taps per window (K)
- `NUM_FILTERS`, 4: filters evaluated in parallel (F)
- `OUT_SHIFT`, 4: requantisation right shift, 0..ACC_W-1
- `clk` in 1: single clock, rising edge
- `rst_n` in 1: asynchronous, active-low reset
- `in_valid` in 1, `in_ready` out 1: input handshake
- `in_data` in K*DATA_W: window, tap k at bits [k*DATA_W +: DATA_W]
- `in_last` in 1: end-of-frame tag, carried with the beat
- `out_valid` out 1, `out_ready` in 1: output handshake
- `out_data` out F*DATA_W: filter f result at [f*DATA_W +: DATA_W]
- `out_last` out 1: tag of the emitted beat
- `out_sat` out F: filter f result was clipped
- `relu_en` in 1: clamp negative results to 0; quasi-static, changed only while the pipe is empty
- `wl_valid` in 1: shadow-bank write strobe
- `wl_addr` in clog2(F*(K+1)): address f*(K+1)+k; k<K is a weight, k==K is the bias
- `wl_data` in ACC_W: weights use the low WEIGHT_W bits, biases use all ACC_W bits
- `swap_req` in 1, `swap_ack` out 1: shadow-to-active copy request and grant

## Operation
- Two banks: shadow, written only via `wl_*`, and active, used by the datapath. Out-of-range `wl_addr` is ignored.
- Per filter f: acc = bias[f] + Σk in[k]·w[f][k]. Each product is sign-extended to ACC_W. Arithmetic wraps modulo 2^ACC_W.
- Datapath structure: a systolic adder chain. Stage k adds the tap-k product. Input samples are delayed so that tap k meets partial sum k. The final stage requantises.
- Requantisation:
  - r = (acc + (OUT_SHIFT>0 ? 2^(OUT_SHIFT-1) : 0)) >>> OUT_SHIFT, rounding half up.
  - If `relu_en` and r<0, then r=0.
  - Saturate r to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
  - `out_sat[f]`=1 iff saturation clipped. ReLU clamping alone does not set it.
- Swap:
  - `swap_ack` = `swap_req` & pipe_empty. pipe_empty means no valid beat in any stage, including the output register.
  - On an acked cycle, active ← shadow at the edge, and `in_ready`=0 that cycle.
  - A `wl_valid` write in the same cycle lands in shadow only; active receives the pre-write shadow contents.
  - Every in-flight beat uses a single weight set.
- Reset (`rst_n` low, asynchronous):
  - Both banks cleared to 0.
  - All stage valids cleared.
  - `out_valid`=0, `out_data`=0, `out_last`=0, `out_sat`=0, `swap_ack`=0.
  - A beat in flight when reset asserts is discarded.

## Timing
- Pipeline enable: en = ~out_valid | out_ready.
- `in_ready` = en & ~swap_ack. A beat is accepted when `in_valid`&`in_ready`.
- Latency: a beat accepted at edge t appears on `out_*` from edge t+K+1, i.e. K+1 cycles, when en stays high.
- Throughput: 1 beat/cycle.
- When en=0:
  - Every stage holds.
  - `out_data`, `out_last` and `out_sat` stay stable while `out_valid`&~`out_ready`.
  - Internal bubbles are not compressed.
- `in_valid` low at an accepted-slot edge injects a bubble (stage valid=0). Bubbles never produce `out_valid`.
- `swap_ack` is combinational from `swap_req` and the registered stage valids. The new weights apply to the first beat accepted on a later cycle.
- No combinational path exists from `in_valid` to `in_ready`, or from `out_ready` to `out_valid`.

## Test plan
- Test parameters for every scenario: K=3, F=2, DATA_W=8, ACC_W=24, OUT_SHIFT=0.
- Basic result: load w0=[1,2,3], b0=0, w1=[-1,0,1], b1=10; swap; window [1,1,1] → 4 cycles later `out_data`={10,6}, `out_sat`=0.
- Streaming and backpressure: 8 back-to-back windows [i,i,i] with `out_ready` toggling 1010… → outputs 6i in order, none lost or duplicated. `out_data` stays stable while stalled, and `out_last` sits on the 8th beat only.
- Saturation and ReLU: window [127,127,127], w0=[127,127,127] → f0 gives 127 with `out_sat[0]`=1. Set w1=[-1,-1,-1], `relu_en`=1 → f1 gives 0 with `out_sat[1]`=0.
- Rounding (OUT_SHIFT=4): acc 24 → 2; acc -24 → -1; acc 8 → 1; acc -8 → 0.
- Swap gating: `swap_req` raised with 3 beats in flight → `swap_ack` stays low until the output drains. Beats before the swap use the old weights and beats after use the new ones. A `wl_valid` write in the ack cycle does not reach active until the next swap.
- Reset mid-stream: drop `rst_n` with beats in flight → outputs are 0 immediately. After release, a window with no swap yields 0 outputs because the weights were cleared.

Source files
------------

// File: rtl/cnn_conv_array.sv
// Systolic multi-filter convolution: bias seeds a partial-sum chain, one tap added per stage, then round/shift/ReLU/saturate.
// Latency K+1 beats; the whole pipe freezes while the output is held (en = ~out_valid | out_ready).
module cnn_conv_array #(
  parameter int DATA_W      = 8,
  parameter int WEIGHT_W    = 8,
  parameter int ACC_W       = 24,
  parameter int WINDOW_SIZE = 9,
  parameter int NUM_FILTERS = 4,
  parameter int OUT_SHIFT   = 4
) (
  input  logic                                            clk,
  input  logic                                            rst_n,
  input  logic                                            in_valid,
  output logic                                            in_ready,
  input  logic [WINDOW_SIZE*DATA_W-1:0]                   in_data,
  input  logic                                            in_last,
  output logic                                            out_valid,
  input  logic                                            out_ready,
  output logic [NUM_FILTERS*DATA_W-1:0]                   out_data,
  output logic                                            out_last,
  output logic [NUM_FILTERS-1:0]                          out_sat,
  input  logic                                            relu_en,
  input  logic                                            wl_valid,
  input  logic [$clog2(NUM_FILTERS*(WINDOW_SIZE+1))-1:0]  wl_addr,
  input  logic [ACC_W-1:0]                                wl_data,
  input  logic                                            swap_req,
  output logic                                            swap_ack
);

  localparam int K  = WINDOW_SIZE;
  localparam int F  = NUM_FILTERS;
  localparam int AW = $clog2(F*(K+1));
  localparam logic signed [ACC_W-1:0] RND  = ACC_W'((2**OUT_SHIFT)/2);
  localparam logic signed [ACC_W-1:0] MAXV = ACC_W'((2**(DATA_W-1))-1);
  localparam logic signed [ACC_W-1:0] MINV = ~MAXV;

  function automatic logic signed [ACC_W-1:0] mac(input logic signed [DATA_W-1:0] a,
                                                  input logic signed [WEIGHT_W-1:0] b);
    logic signed [DATA_W+WEIGHT_W-1:0] p;
    p = a * b;
    return ACC_W'(p);
  endfunction

  // Returns {clipped, result}; ReLU clamping is applied before saturation and never flags a clip.
  function automatic logic [DATA_W:0] requant(input logic signed [ACC_W-1:0] acc, input logic relu);
    logic signed [ACC_W-1:0] r;
    r = (acc + RND) >>> OUT_SHIFT;
    if (relu && r < 0) r = '0;
    if (r > MAXV)      return {1'b1, MAXV[DATA_W-1:0]};
    else if (r < MINV) return {1'b1, MINV[DATA_W-1:0]};
    else               return {1'b0, r[DATA_W-1:0]};
  endfunction

  logic signed [WEIGHT_W-1:0] shd_w [F][K];
  logic signed [WEIGHT_W-1:0] act_w [F][K];
  logic signed [ACC_W-1:0]    shd_b [F];
  logic signed [ACC_W-1:0]    act_b [F];

  logic [K:0] vld;
  logic [K:0] lst;
  logic       en;
  logic       pipe_empty;

  assign en         = ~out_valid | out_ready;
  assign pipe_empty = ~(|vld) & ~out_valid;
  assign swap_ack   = swap_req & pipe_empty & rst_n;
  assign in_ready   = en & ~swap_ack;

  // Active bank takes the pre-write shadow image when a write and a swap share a cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int f = 0; f < F; f++) begin
        shd_b[f] <= '0;
        act_b[f] <= '0;
        for (int k = 0; k < K; k++) begin
          shd_w[f][k] <= '0;
          act_w[f][k] <= '0;
        end
      end
    end else begin
      if (swap_ack) begin
        act_w <= shd_w;
        act_b <= shd_b;
      end
      if (wl_valid) begin
        for (int f = 0; f < F; f++) begin
          for (int k = 0; k < K; k++)
            if (wl_addr == AW'(f*(K+1)+k)) shd_w[f][k] <= wl_data[WEIGHT_W-1:0];
          if (wl_addr == AW'(f*(K+1)+K)) shd_b[f] <= wl_data;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld <= '0;
      lst <= '0;
    end else if (en) begin
      vld <= {vld[K-1:0], in_valid & in_ready};
      lst <= {lst[K-1:0], in_last};
    end
  end

  logic signed [ACC_W-1:0] ps0     [F];
  logic signed [ACC_W-1:0] ps_last [F];

  always_ff @(posedge clk) begin
    if (en) ps0 <= act_b;
  end

  // Tap k is delayed k+1 cycles so it meets the partial sum at chain stage k+1.
  for (genvar k = 0; k < K; k++) begin : g_tap
    logic signed [DATA_W-1:0] dly  [k+1];
    logic signed [ACC_W-1:0]  prev [F];
    logic signed [ACC_W-1:0]  ps   [F];

    if (k == 0) begin : g_first
      assign prev = ps0;
    end else begin : g_next
      assign prev = g_tap[k-1].ps;
    end

    if (k == K-1) begin : g_last
      assign ps_last = ps;
    end

    always_ff @(posedge clk) begin
      if (en) begin
        dly[0] <= in_data[k*DATA_W +: DATA_W];
        for (int j = 1; j <= k; j++) dly[j] <= dly[j-1];
        for (int f = 0; f < F; f++) ps[f] <= prev[f] + mac(dly[k], act_w[f][k]);
      end
    end
  end

  logic [F*DATA_W-1:0] nx_data;
  logic [F-1:0]        nx_sat;

  always_comb begin
    nx_data = '0;
    nx_sat  = '0;
    for (int f = 0; f < F; f++)
      {nx_sat[f], nx_data[f*DATA_W +: DATA_W]} = requant(ps_last[f], relu_en);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      out_sat   <= '0;
    end else if (en) begin
      out_valid <= vld[K];
      out_data  <= nx_data;
      out_last  <= lst[K];
      out_sat   <= nx_sat;
    end
  end

endmodule

// File: tb/tb_cnn_conv_array.sv
// Directed bench for cnn_conv_array with K=3, F=2; a second instance with OUT_SHIFT=4 checks rounding.
module tb_cnn_conv_array;

  localparam int K  = 3;
  localparam int F  = 2;
  localparam int DW = 8;
  localparam int AW = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready, in_ready_r;
  logic [K*DW-1:0] in_data = '0;
  logic          in_last = 1'b0;
  logic          out_valid, out_valid_r;
  logic          out_ready = 1'b1;
  logic [F*DW-1:0] out_data, out_data_r;
  logic          out_last, out_last_r;
  logic [F-1:0]  out_sat, out_sat_r;
  logic          relu_en = 1'b0;
  logic          wl_valid = 1'b0;
  logic [AW-1:0] wl_addr = '0;
  logic [23:0]   wl_data = '0;
  logic          swap_req = 1'b0;
  logic          swap_ack, swap_ack_r;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  cnn_conv_array #(.DATA_W(8), .WEIGHT_W(8), .ACC_W(24), .WINDOW_SIZE(K), .NUM_FILTERS(F), .OUT_SHIFT(0)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .out_sat(out_sat), .relu_en(relu_en), .wl_valid(wl_valid),
    .wl_addr(wl_addr), .wl_data(wl_data), .swap_req(swap_req), .swap_ack(swap_ack));

  cnn_conv_array #(.DATA_W(8), .WEIGHT_W(8), .ACC_W(24), .WINDOW_SIZE(K), .NUM_FILTERS(F), .OUT_SHIFT(4)) dut_r (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_r), .in_data(in_data),
    .in_last(in_last), .out_valid(out_valid_r), .out_ready(out_ready), .out_data(out_data_r),
    .out_last(out_last_r), .out_sat(out_sat_r), .relu_en(relu_en), .wl_valid(wl_valid),
    .wl_addr(wl_addr), .wl_data(wl_data), .swap_req(swap_req), .swap_ack(swap_ack_r));

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int addr, input int val);
    wl_valid = 1'b1;
    wl_addr  = AW'(addr);
    wl_data  = 24'(val);
    step;
    wl_valid = 1'b0;
  endtask

  task automatic load(input int a0, input int a1, input int a2, input int b0,
                      input int c0, input int c1, input int c2, input int b1);
    wr(0, a0); wr(1, a1); wr(2, a2); wr(3, b0);
    wr(4, c0); wr(5, c1); wr(6, c2); wr(7, b1);
  endtask

  task automatic do_swap;
    bit got = 0;
    swap_req = 1'b1;
    for (int c = 0; c < 50 && !got; c++) begin
      if (swap_ack) got = 1;
      else step;
    end
    checks++;
    if (!got) begin errors++; $display("FAIL swap_timeout: ack=%0b required 1", swap_ack); end
    step;
    swap_req = 1'b0;
  endtask

  task automatic send_win(input logic [K*DW-1:0] w, output logic [15:0] d, output logic [15:0] dr,
                          output logic [1:0] s, output bit got);
    got = 0; d = '0; dr = '0; s = '0;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = w;
    in_last   = 1'b0;
    step;
    in_valid = 1'b0;
    for (int c = 0; c < 20 && !got; c++) begin
      if (out_valid) begin d = out_data; dr = out_data_r; s = out_sat; got = 1; end
      step;
    end
  endtask

  task automatic test_reset;
    swap_req = 1'b1;
    #12;
    checks++;
    if (out_valid !== 1'b0 || out_last !== 1'b0) begin
      errors++; $display("FAIL reset_ctl: valid=%b last=%b required 0 0", out_valid, out_last);
    end
    checks++;
    if (out_data !== 16'h0000 || out_sat !== 2'b00) begin
      errors++; $display("FAIL reset_data: data=%h sat=%b required 0000 00", out_data, out_sat);
    end
    checks++;
    if (swap_ack !== 1'b0) begin errors++; $display("FAIL reset_ack: got %b required 0", swap_ack); end
    swap_req = 1'b0;
    step;
    rst_n = 1'b1;
    step;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL idle_ready: got %b required 1", in_ready); end
  endtask

  task automatic test_basic;
    load(1, 2, 3, 0, -1, 0, 1, 10);
    do_swap;
    out_ready = 1'b1;
    in_valid = 1'b1;
    in_data = {8'd1, 8'd1, 8'd1};
    step;
    in_valid = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      step;
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_early c=%0d: valid=%b required 0", c, out_valid); end
    end
    step;
    checks++;
    if (out_valid !== 1'b1 || out_data !== 16'h0A06 || out_sat !== 2'b00) begin
      errors++; $display("FAIL basic_result: valid=%b data=%h sat=%b required 1 0a06 00", out_valid, out_data, out_sat);
    end
    step;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_bubble: valid=%b required 0", out_valid); end
  endtask

  task automatic test_stream;
    int idx = 1;
    int rcv = 0;
    bit prev_stall = 0;
    bit acc;
    bit extra = 0;
    logic [15:0] prev_d = '0;
    for (int c = 0; c < 200 && rcv < 8; c++) begin
      out_ready = (c % 2 == 0);
      if (idx <= 8) begin
        in_valid = 1'b1; in_data = {3{8'(idx)}}; in_last = (idx == 8);
      end else begin
        in_valid = 1'b0; in_last = 1'b0;
      end
      #3;
      if (prev_stall) begin
        checks++;
        if (out_valid !== 1'b1 || out_data !== prev_d) begin
          errors++; $display("FAIL stream_hold: valid=%b data=%h required 1 %h", out_valid, out_data, prev_d);
        end
      end
      if (out_valid && out_ready) begin
        rcv++;
        checks++;
        if (out_data !== {8'd10, 8'(6*rcv)} || out_last !== (rcv == 8) || out_sat !== 2'b00) begin
          errors++;
          $display("FAIL stream_beat%0d: data=%h last=%b sat=%b required %h %b 00",
                   rcv, out_data, out_last, out_sat, {8'd10, 8'(6*rcv)}, (rcv == 8));
        end
      end
      prev_stall = out_valid & ~out_ready;
      prev_d = out_data;
      acc = in_valid & in_ready;
      @(posedge clk);
      #1;
      if (acc) idx++;
    end
    in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b1;
    checks++;
    if (rcv !== 8) begin errors++; $display("FAIL stream_count: got %0d beats required 8", rcv); end
    for (int c = 0; c < 6; c++) begin
      if (out_valid) extra = 1;
      step;
    end
    checks++;
    if (extra) begin errors++; $display("FAIL stream_dup: extra out_valid=1 required 0"); end
  endtask

  task automatic test_sat_relu;
    logic [15:0] d, dr;
    logic [1:0] s;
    bit got;
    load(127, 127, 127, 0, -1, -1, -1, 0);
    do_swap;
    relu_en = 1'b1;
    send_win({8'd127, 8'd127, 8'd127}, d, dr, s, got);
    checks++;
    if (!got || d !== 16'h007F || s !== 2'b01) begin
      errors++; $display("FAIL sat_relu: got=%0b data=%h sat=%b required 1 007f 01", got, d, s);
    end
    relu_en = 1'b0;
    send_win({8'd127, 8'd127, 8'd127}, d, dr, s, got);
    checks++;
    if (!got || d !== 16'h807F || s !== 2'b11) begin
      errors++; $display("FAIL sat_both: got=%0b data=%h sat=%b required 1 807f 11", got, d, s);
    end
  endtask

  task automatic test_round;
    logic [15:0] d, dr;
    logic [1:0] s;
    bit got;
    load(1, 0, 0, 0, -1, 0, 0, 0);
    do_swap;
    send_win({8'd0, 8'd0, 8'd24}, d, dr, s, got);
    checks++;
    if (!got || dr !== 16'hFF02) begin
      errors++; $display("FAIL round_24: got=%0b data=%h required 1 ff02", got, dr);
    end
    checks++;
    if (d !== 16'hE818) begin errors++; $display("FAIL noshift_24: data=%h required e818", d); end
    send_win({8'd0, 8'd0, 8'd8}, d, dr, s, got);
    checks++;
    if (!got || dr !== 16'h0001) begin
      errors++; $display("FAIL round_8: got=%0b data=%h required 1 0001", got, dr);
    end
  endtask

  task automatic test_swap_gating;
    logic [15:0] exp_q [3] = '{16'hF60A, 16'hEC14, 16'hE21E};
    logic [15:0] d, dr;
    logic [1:0] s;
    bit got;
    bit acked = 0;
    int rcv = 0;
    load(2, 0, 0, 0, 0, 0, 0, 5);
    out_ready = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      in_valid = 1'b1;
      in_data = {8'd0, 8'd0, 8'(10*i)};
      step;
    end
    in_valid = 1'b0;
    swap_req = 1'b1;
    for (int c = 0; c < 30 && !acked; c++) begin
      if (out_valid) begin
        checks++;
        if (swap_ack !== 1'b0) begin errors++; $display("FAIL swap_early: ack=%b required 0", swap_ack); end
        checks++;
        if (rcv < 3 && out_data !== exp_q[rcv]) begin
          errors++; $display("FAIL swap_old%0d: data=%h required %h", rcv, out_data, exp_q[rcv]);
        end
        rcv++;
      end
      if (swap_ack) begin
        acked = 1;
        checks++;
        if (rcv !== 3 || in_ready !== 1'b0) begin
          errors++; $display("FAIL swap_ack_cycle: drained=%0d in_ready=%b required 3 0", rcv, in_ready);
        end
        wl_valid = 1'b1; wl_addr = 3'd0; wl_data = 24'd7;
        step;
        wl_valid = 1'b0; swap_req = 1'b0;
      end else begin
        step;
      end
    end
    swap_req = 1'b0;
    checks++;
    if (!acked) begin errors++; $display("FAIL swap_gate_timeout: ack=%b required 1", swap_ack); end
    send_win({8'd0, 8'd0, 8'd3}, d, dr, s, got);
    checks++;
    if (!got || d !== 16'h0506) begin
      errors++; $display("FAIL swap_new: got=%0b data=%h required 1 0506", got, d);
    end
    do_swap;
    send_win({8'd0, 8'd0, 8'd3}, d, dr, s, got);
    checks++;
    if (!got || d !== 16'h0515) begin
      errors++; $display("FAIL swap_late_write: got=%0b data=%h required 1 0515", got, d);
    end
  endtask

  task automatic test_reset_mid;
    logic [15:0] d, dr;
    logic [1:0] s;
    bit got;
    bit seen = 0;
    bit leak = 0;
    out_ready = 1'b1;
    in_valid = 1'b1; in_data = {8'd0, 8'd0, 8'd5};
    step;
    in_data = {8'd0, 8'd0, 8'd6};
    step;
    in_valid = 1'b0;
    out_ready = 1'b0;
    for (int c = 0; c < 10 && !seen; c++) begin
      if (out_valid) seen = 1;
      else step;
    end
    checks++;
    if (!seen || out_data !== 16'h0523) begin
      errors++; $display("FAIL pre_reset: valid=%b data=%h required 1 0523", out_valid, out_data);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_data !== 16'h0000 || out_sat !== 2'b00 || out_last !== 1'b0) begin
      errors++; $display("FAIL mid_reset: valid=%b data=%h sat=%b last=%b required 0 0000 00 0",
                         out_valid, out_data, out_sat, out_last);
    end
    #1 rst_n = 1'b1;
    out_ready = 1'b1;
    step;
    for (int c = 0; c < 8; c++) begin
      if (out_valid) leak = 1;
      step;
    end
    checks++;
    if (leak) begin errors++; $display("FAIL reset_discard: stale out_valid=1 required 0"); end
    send_win({8'd1, 8'd1, 8'd1}, d, dr, s, got);
    checks++;
    if (!got || d !== 16'h0000 || s !== 2'b00) begin
      errors++; $display("FAIL reset_weights: got=%0b data=%h sat=%b required 1 0000 00", got, d, s);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset;
    test_basic;
    test_stream;
    test_sat_relu;
    test_round;
    test_swap_gating;
    test_reset_mid;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
